// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and width defaults for the MEM stage
package mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // Size 2'b11 behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

    // Snap the low address bits onto the naturally aligned lane for the access size.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_unit_if.sv
// rtl/mem_stage_unit_if.sv - req/ack data-memory port bundle
interface mem_stage_unit_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication and load extraction
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    size,
    input  logic          is_unsigned,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] rdata,
    output logic [3:0]    be,
    output logic [DW-1:0] wdata_lane,
    output logic [DW-1:0] rdata_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection for both directions; addr_lo is already aligned to the size.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
        byte_lane  = rdata[{addr_lo, 3'b000} +: 8];
        half_lane  = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MEM stage: data-memory access, stall and MEM/WB register (MEM_MISALIGN_TRAP_EN enables misalignment trap)
module mem_stage_unit
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_mem_read,
    input  logic          in_mem_write,
    input  logic [1:0]    in_size,
    input  logic          in_unsigned,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic [RW-1:0] in_rd,
    input  logic          in_reg_write,
    output logic          stall,
    mem_stage_unit_if.master dmem,
    output logic          wb_valid,
    output logic          wb_reg_write,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    output logic          wb_exc
);

    if (DW != 32) begin : g_dw_check
        $error("mem_stage_unit: DW must be 32");
    end

    mem_state_e state;
    mem_state_e next_state;

    logic          mem_op;
    logic          trap;
    logic          start;
    logic [1:0]    in_lo;

    logic [1:0]    cap_size;
    logic          cap_unsigned;
    logic [1:0]    cap_lo;
    logic [RW-1:0] cap_rd;
    logic          cap_reg_write;
    logic          cap_store;
    logic [AW-1:0] cap_addr;

    logic [1:0]    al_size;
    logic          al_unsigned;
    logic [1:0]    al_lo;
    logic [3:0]    lane_be;
    logic [DW-1:0] lane_wdata;
    logic [DW-1:0] lane_rdata;

    assign mem_op = in_mem_read | in_mem_write;
    assign in_lo  = align_lo(in_size, in_addr[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = in_valid & mem_op & is_misaligned(in_size, in_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign start = in_valid & mem_op & ~trap;

    // In IDLE the lane unit shapes the incoming store; in BUSY it extracts the captured load.
    assign al_size     = (state == BUSY) ? cap_size     : in_size;
    assign al_unsigned = (state == BUSY) ? cap_unsigned : in_unsigned;
    assign al_lo       = (state == BUSY) ? cap_lo       : in_lo;

    mem_lane_align #(.DW(DW)) u_lane_align (
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .addr_lo     (al_lo),
        .wdata       (in_wdata),
        .rdata       (dmem.rdata),
        .be          (lane_be),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (lane_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and stall; stall is forced low while reset is asserted.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = BUSY;
                    stall      = 1'b1;
                end
            end
            BUSY: begin
                stall = ~dmem.ack;
                if (dmem.ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (!rst) begin
            stall = 1'b0;
        end
    end

    // Memory request, captured access context and the MEM/WB register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem.req      <= 1'b0;
            dmem.we       <= 1'b0;
            dmem.addr     <= '0;
            dmem.be       <= '0;
            dmem.wdata    <= '0;
            cap_size      <= SZ_BYTE;
            cap_unsigned  <= 1'b0;
            cap_lo        <= 2'b00;
            cap_rd        <= '0;
            cap_reg_write <= 1'b0;
            cap_store     <= 1'b0;
            cap_addr      <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            wb_exc        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_exc   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem.req      <= 1'b1;
                        dmem.we       <= in_mem_write;
                        dmem.addr     <= {in_addr[AW-1:2], 2'b00};
                        dmem.be       <= lane_be;
                        dmem.wdata    <= in_mem_write ? lane_wdata : '0;
                        cap_size      <= in_size;
                        cap_unsigned  <= in_unsigned;
                        cap_lo        <= in_lo;
                        cap_rd        <= in_rd;
                        cap_reg_write <= in_reg_write;
                        cap_store     <= in_mem_write;
                        cap_addr      <= in_addr;
                    end else if (in_valid) begin
                        wb_valid     <= 1'b1;
                        wb_exc       <= trap;
                        wb_reg_write <= in_reg_write & ~trap;
                        wb_rd        <= in_rd;
                        wb_data      <= DW'(in_addr);
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        dmem.req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_reg_write <= cap_reg_write;
                        wb_rd        <= cap_rd;
                        wb_data      <= cap_store ? DW'(cap_addr) : lane_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - self-checking bench for mem_stage_unit
module tb_mem_stage_unit;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        stall;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exc;

    int nvec  = 0;
    int nfail = 0;

    mem_stage_unit_if #(.AW(32), .DW(32)) dmem_bus ();

    mem_stage_unit #(.AW(32), .DW(32), .RW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_size      (in_size),
        .in_unsigned  (in_unsigned),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .stall        (stall),
        .dmem         (dmem_bus),
        .wb_valid     (wb_valid),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exc       (wb_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a % 4);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (lo % 2) != 0;
        return lo != 0;
    endfunction

    function automatic int model_lo(input logic [1:0] sz, input logic [31:0] a);
        int lo = int'(a % 4);
        if (sz == 2'd1) return lo - (lo % 2);
        if (sz != 2'd0) return 0;
        return lo;
    endfunction

    function automatic logic [31:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        int lo = model_lo(sz, a);
        if (sz == 2'd0) return 32'd1 << lo;
        if (sz == 2'd1) return 32'd3 << lo;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a, input logic [31:0] r);
        int lo = model_lo(sz, a);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (r >> (8 * lo)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
            return v;
        end
        if (sz == 2'd1) begin
            v = (r >> (8 * lo)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
            return v;
        end
        return r;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. delay = idle BUSY cycles before ack.
    task automatic do_op(input int kind, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input bit regw, input bit both, input int delay);
        bit is_mem;
        bit trap;
        logic [31:0] exp_data;
        @(negedge clk);
        dmem_bus.ack   = 1'b0;
        in_valid       = 1'b1;
        in_mem_read    = (kind == 1) || (kind == 2 && both);
        in_mem_write   = (kind == 2);
        in_size        = sz;
        in_unsigned    = uns;
        in_addr        = addr;
        in_wdata       = wdata;
        in_rd          = rd;
        in_reg_write   = regw;
        is_mem         = (kind != 0);
        trap           = TRAP_EN && is_mem && model_misaligned(sz, addr);
        #1 chk("stall_issue", 32'(stall), 32'(is_mem && !trap));
        @(posedge clk); #1;
        if (!is_mem || trap) begin
            chk("wb_valid_alu", 32'(wb_valid), 32'd1);
            chk("wb_data_alu", wb_data, addr);
            chk("wb_rd_alu", 32'(wb_rd), 32'(rd));
            chk("wb_regw_alu", 32'(wb_reg_write), 32'(regw && !trap));
            chk("wb_exc_alu", 32'(wb_exc), 32'(trap));
            chk("req_alu", 32'(dmem_bus.req), 32'd0);
        end else begin
            chk("req_issue", 32'(dmem_bus.req), 32'd1);
            chk("wb_valid_issue", 32'(wb_valid), 32'd0);
            chk("we_issue", 32'(dmem_bus.we), 32'(kind == 2));
            chk("addr_issue", dmem_bus.addr, addr & 32'hFFFF_FFFC);
            if (kind == 2) begin
                chk("be_issue", 32'(dmem_bus.be), model_be(sz, addr));
                chk("wdata_issue", dmem_bus.wdata, model_wdata(sz, wdata));
            end
            exp_data = (kind == 2) ? addr : model_load(sz, uns, addr, rdata);
            for (int k = 0; k <= delay; k++) begin
                @(negedge clk);
                dmem_bus.ack   = (k == delay);
                dmem_bus.rdata = (k == delay) ? rdata : $urandom;
                #1;
                chk("stall_busy", 32'(stall), 32'(k != delay));
                chk("req_hold", 32'(dmem_bus.req), 32'd1);
                chk("addr_hold", dmem_bus.addr, addr & 32'hFFFF_FFFC);
                @(posedge clk); #1;
                if (k == delay) begin
                    chk("wb_valid_done", 32'(wb_valid), 32'd1);
                    chk("wb_rd_done", 32'(wb_rd), 32'(rd));
                    chk("wb_regw_done", 32'(wb_reg_write), 32'(regw));
                    chk("wb_data_done", wb_data, exp_data);
                    chk("wb_exc_done", 32'(wb_exc), 32'd0);
                    chk("req_done", 32'(dmem_bus.req), 32'd0);
                end else begin
                    chk("wb_valid_wait", 32'(wb_valid), 32'd0);
                end
            end
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid      = 1'b0;
        in_mem_read   = 1'b0;
        in_mem_write  = 1'b0;
        dmem_bus.ack  = 1'b0;
        #1 chk("stall_idle", 32'(stall), 32'd0);
        @(posedge clk); #1;
        chk("wb_valid_idle", 32'(wb_valid), 32'd0);
        chk("req_idle", 32'(dmem_bus.req), 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b1;
        in_mem_read    = 1'b1;
        in_mem_write   = 1'b0;
        in_size        = 2'd2;
        in_unsigned    = 1'b0;
        in_addr        = 32'h0000_0040;
        in_wdata       = 32'h0;
        in_rd          = 5'd1;
        in_reg_write   = 1'b1;
        dmem_bus.ack   = 1'b0;
        dmem_bus.rdata = 32'h0;

        #12;
        chk("rst_req", 32'(dmem_bus.req), 32'd0);
        chk("rst_we", 32'(dmem_bus.we), 32'd0);
        chk("rst_addr", dmem_bus.addr, 32'd0);
        chk("rst_be", 32'(dmem_bus.be), 32'd0);
        chk("rst_wdata", dmem_bus.wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_regw", 32'(wb_reg_write), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_exc", 32'(wb_exc), 32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;

        do_op(0, 2'd0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 0);
        idle_cycle();
        do_op(2, 2'd0, 1'b0, 32'h103, 32'hAB, 32'h0, 5'd7, 1'b0, 1'b0, 2);
        idle_cycle();
        do_op(1, 2'd1, 1'b0, 32'h202, 32'h0, 32'h8001_0000, 5'd9, 1'b1, 1'b0, 1);
        do_op(1, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 5'd10, 1'b1, 1'b0, 1);
        do_op(1, 2'd2, 1'b0, 32'h400, 32'h0, 32'hDEAD_BEEF, 5'd11, 1'b1, 1'b0, 0);
        do_op(1, 2'd2, 1'b0, 32'h404, 32'h0, 32'h1357_9BDF, 5'd12, 1'b1, 1'b0, 0);
        idle_cycle();
        do_op(2, 2'd1, 1'b0, 32'h502, 32'h1234_CAFE, 32'h0, 5'd3, 1'b0, 1'b1, 0);
        do_op(1, 2'd2, 1'b0, 32'h301, 32'h0, 32'h0BAD_F00D, 5'd4, 1'b1, 1'b0, 0);
        idle_cycle();

        // Reset in the middle of an outstanding load, then a stray ack.
        @(negedge clk);
        in_valid     = 1'b1;
        in_mem_read  = 1'b1;
        in_mem_write = 1'b0;
        in_size      = 2'd2;
        in_addr      = 32'h0000_0600;
        @(posedge clk); #1;
        chk("req_before_rst", 32'(dmem_bus.req), 32'd1);
        @(negedge clk);
        #1 chk("stall_before_rst", 32'(stall), 32'd1);
        rst = 1'b0;
        #1;
        chk("req_rst_busy", 32'(dmem_bus.req), 32'd0);
        chk("stall_rst_busy", 32'(stall), 32'd0);
        chk("wb_valid_rst_busy", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_mem_read  = 1'b0;
        dmem_bus.ack = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1 chk("stall_stray_ack", 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk("wb_valid_stray_ack", 32'(wb_valid), 32'd0);
            chk("req_stray_ack", 32'(dmem_bus.req), 32'd0);
            @(negedge clk);
        end
        dmem_bus.ack = 1'b0;

        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            do_op(kind, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'($urandom), 32'($urandom), 32'($urandom), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Drives a req/ack data-memory port: byte/half/word loads and stores.
- Produces the registered MEM/WB bundle.
- Issues a stall that holds the EX/MEM register (EX/MEM Load = ~stall) while a memory access is outstanding.

Parameters:
- AW, 32, data-memory address width
- DW, 32, data width; fixed at 32, asserted at elaboration
- RW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM bundle holds a live instruction
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- in_unsigned  in  1  zero-extend loads
- in_addr  in  AW  effective address (ALU result)
- in_wdata  in  DW  store data
- in_rd  in  RW  destination register
- in_reg_write  in  1  writeback enable
- stall  out  1  hold EX/MEM register and upstream stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  DW  lane-replicated store data
- dmem_rdata  in  DW  read data, valid with ack
- dmem_ack  in  1  request completed
- wb_valid  out  1  MEM/WB bundle valid
- wb_reg_write  out  1  writeback enable
- wb_rd  out  RW  destination
- wb_data  out  DW  load result or passed-through address/ALU result
- wb_exc  out  1  misaligned-access exception (only with feature)

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All outputs 0: dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_reg_write, wb_rd, wb_data, wb_exc.
  - stall=0.
- FSM states: IDLE, BUSY.
- IDLE, in_valid with no memory op:
  - Next edge: wb_valid=1, wb_data=in_addr, wb_rd/wb_reg_write copied.
  - Latency 1, no stall.
- IDLE, in_valid with mem_read or mem_write:
  - stall=1 combinationally in that same cycle.
  - Next edge: dmem_req=1 and dmem_we/addr/be/wdata registered; rd, size, unsigned and addr[1:0] captured internally; go to BUSY.
  - wb_valid=0 on that edge.
- in_mem_read and in_mem_write both set: treated as store.
- BUSY:
  - dmem_req and all dmem_* stay stable until dmem_ack.
  - stall = ~dmem_ack.
  - Edge with dmem_ack=1:
    - dmem_req=0.
    - wb_valid=1, wb_rd and wb_reg_write from the captured values.
    - wb_data = extracted load data, or captured addr for a store.
    - Back to IDLE.
  - Minimum access latency is 2 cycles (ack on the first req cycle).
- dmem_ack while in IDLE: ignored.
- wb_valid is a one-cycle pulse per instruction; 0 in every cycle with no completing instruction.
- Store byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- Store data lanes:
  - byte: wdata[7:0] replicated to all four lanes
  - half: wdata[15:0] replicated to both halves
  - word: unchanged
- Load extraction: select the byte/half lane by captured addr[1:0]; sign-extend unless unsigned; word taken as-is.
- Misalignment (half with addr[0]=1, word with addr[1:0]!=0) when the feature is off:
  - Low address bits forced to the aligned lane (half: addr[0] ignored; word: addr[1:0] ignored).
  - wb_exc stays 0.
- Async reset mid-BUSY: request dropped at once; the access in flight is lost.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined, misaligned memory op in IDLE:
  - No dmem_req, no stall.
  - Next edge: wb_valid=1, wb_exc=1, wb_reg_write=0, wb_data=in_addr.
- Undefined: wb_exc tied 0; misalignment handled by forcing alignment as in Behaviour.

Decomposition:
- Shared package mem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, AW/DW/RW defaults.
- One sub-module: mem_lane_align (combinational). Computes be, store-data replication and load extraction/extension from size, unsigned and addr[1:0].

Test Plan:
- Reset, then ALU op: in_valid=1, in_addr=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; stall never high.
- Byte store: addr=0x103, wdata=0xAB, size=00 -> dmem_req, we=1, dmem_addr=0x100, be=1000, wdata=0xABABABAB held 3 cycles until ack on 3rd; stall high until the ack cycle.
- Signed half load: addr=0x202, rdata=0x8001_0000, ack after 1 cycle -> wb_data=0xFFFF8001; unsigned -> 0x00008001.
- Back-to-back word loads with immediate ack -> each completes in 2 cycles; second held in EX/MEM via stall; no lost or duplicated wb_valid.
- rst=0 asserted in BUSY -> dmem_req and stall drop immediately; after release, stray ack ignored, wb_valid stays 0.
- With MEM_MISALIGN_TRAP_EN: word load at 0x301 -> no dmem_req; next cycle wb_valid=1, wb_exc=1, wb_reg_write=0.
